register_file_mp: RTL and testbench

- Parametrised successor to the team's 32x32 register file.
- Configurable data width and depth, two write ports with a fixed conflict rule, two registered read ports with hold-on-disable, optional write-to-read bypass, and optional hard-wired zero register.
- Sits in the CPU datapath between decode (read addresses) and writeback (two write ports: ALU result and load result).

---
 rtl/register_file_mp_if.sv | 28 ++
 rtl/register_file_mp.sv | 56 +++++
 tb/tb_register_file_mp.sv | 100 ++++++++++
 3 files changed

// File: rtl/register_file_mp_if.sv
// register_file_mp_if: read/write bus of the multi-port register file.
interface register_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [ADDR_WIDTH-1:0] addr2;
  logic [DATA_WIDTH-1:0] out1;
  logic [DATA_WIDTH-1:0] out2;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  write_enable_b;
  logic [ADDR_WIDTH-1:0] in_addr_b;
  logic [DATA_WIDTH-1:0] in_data_b;
  logic                  conflict;
  modport master (
    output read_enable, addr1, addr2, write_enable, in_addr, in_data,
           write_enable_b, in_addr_b, in_data_b,
    input  out1, out2, conflict
  );
  modport slave (
    input  read_enable, addr1, addr2, write_enable, in_addr, in_data,
           write_enable_b, in_addr_b, in_data_b,
    output out1, out2, conflict
  );
endinterface

// File: rtl/register_file_mp.sv
// register_file_mp: two-write, two-read registered register file with
// port-B-wins conflict rule, optional bypass and optional zero register.
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input logic clk,
  input logic reset,
  register_file_mp_if.slave bus
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH + 1)'(DEPTH);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_out [2];
  logic                  r_conf;
  logic                  w_va, w_vb, w_conf;
  logic [ADDR_WIDTH-1:0] w_ra [2];
  logic [DATA_WIDTH-1:0] w_rd [2];
  function automatic logic ok(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < LIM) && !(ZERO_REG != 0 && a == '0);
  endfunction
  assign w_va   = bus.write_enable && ok(bus.in_addr);
  assign w_vb   = bus.write_enable_b && ok(bus.in_addr_b);
  assign w_conf = w_va && w_vb && bus.in_addr == bus.in_addr_b;
  assign w_ra[0] = bus.addr1;
  assign w_ra[1] = bus.addr2;
  // Port B is checked first so it wins the forward, matching the array update.
  always_comb
    for (int p = 0; p < 2; p++)
      w_rd[p] = !ok(w_ra[p]) ? '0 :
                (BYPASS != 0 && w_vb && bus.in_addr_b == w_ra[p]) ? bus.in_data_b :
                (BYPASS != 0 && w_va && bus.in_addr == w_ra[p]) ? bus.in_data :
                r_mem[w_ra[p][IW-1:0]];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_out[0] <= '0;
      r_out[1] <= '0;
      r_conf   <= 1'b0;
    end else begin
      if (w_va) r_mem[bus.in_addr[IW-1:0]] <= bus.in_data;
      if (w_vb) r_mem[bus.in_addr_b[IW-1:0]] <= bus.in_data_b;
      if (bus.read_enable) begin
        r_out[0] <= w_rd[0];
        r_out[1] <= w_rd[1];
      end
      r_conf <= w_conf;
    end
  end
  assign bus.out1     = r_out[0];
  assign bus.out2     = r_out[1];
  assign bus.conflict = r_conf;
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed vectors against two configurations
// (DUT0: 32 deep, zero reg, bypass; DUT1: 16 deep, no zero reg, no bypass).
module tb_register_file_mp;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  register_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) b0 ();
  register_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) b1 ();
  register_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32), .ZERO_REG(1), .BYPASS(1))
    u0 (.clk(clk), .reset(rst), .bus(b0));
  register_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16), .ZERO_REG(0), .BYPASS(0))
    u1 (.clk(clk), .reset(rst), .bus(b1));
  typedef struct {
    int rst, re, a1, a2, we, ia, da, web, ib, db;
    int e1, e2, ec, f1, f2, fc;
  } vec_t;
  vec_t v [17];
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step(input int r, re, a1, a2, we, ia, da, web, ib, db);
    rst = r[0];
    b0.read_enable = re[0];     b1.read_enable = re[0];
    b0.addr1 = a1[4:0];         b1.addr1 = a1[4:0];
    b0.addr2 = a2[4:0];         b1.addr2 = a2[4:0];
    b0.write_enable = we[0];    b1.write_enable = we[0];
    b0.in_addr = ia[4:0];       b1.in_addr = ia[4:0];
    b0.in_data = da;            b1.in_data = da;
    b0.write_enable_b = web[0]; b1.write_enable_b = web[0];
    b0.in_addr_b = ib[4:0];     b1.in_addr_b = ib[4:0];
    b0.in_data_b = db;          b1.in_data_b = db;
    @(posedge clk);
    #1;
  endtask
  initial begin
    //        rst re a1 a2 we ia da   web ib db    | DUT0 out1 out2 conf | DUT1 out1 out2 conf
    v[0]  = '{1, 0, 0, 0, 0, 0, 0,    0, 0, 0,      0,    0,    0,    0,    0,    0};
    v[1]  = '{0, 1, 0, 2, 0, 0, 0,    0, 0, 0,      0,    0,    0,    0,    0,    0};
    v[2]  = '{0, 1, 0, 2, 1, 2, 2222, 0, 0, 0,      0,    2222, 0,    0,    0,    0};
    v[3]  = '{0, 1, 0, 2, 0, 0, 0,    0, 0, 0,      0,    2222, 0,    0,    2222, 0};
    v[4]  = '{0, 1, 0, 2, 1, 0, 1234, 0, 0, 0,      0,    2222, 0,    0,    2222, 0};
    v[5]  = '{0, 1, 0, 0, 0, 0, 0,    0, 0, 0,      0,    0,    0,    1234, 1234, 0};
    v[6]  = '{0, 1, 5, 5, 1, 5, 5678, 1, 5, 9999,   9999, 9999, 1,    0,    0,    1};
    v[7]  = '{0, 1, 5, 2, 1, 6, 11,   1, 7, 22,     9999, 2222, 0,    9999, 2222, 0};
    v[8]  = '{0, 1, 6, 7, 0, 0, 0,    0, 0, 0,      11,   22,   0,    11,   22,   0};
    v[9]  = '{0, 1, 1, 2, 1, 2, 5678, 0, 0, 0,      0,    5678, 0,    0,    2222, 0};
    v[10] = '{0, 1, 1, 2, 0, 0, 0,    0, 0, 0,      0,    5678, 0,    0,    5678, 0};
    v[11] = '{0, 0, 1, 2, 1, 2, 4321, 0, 0, 0,      0,    5678, 0,    0,    5678, 0};
    v[12] = '{0, 1, 1, 2, 0, 0, 0,    0, 0, 0,      0,    4321, 0,    0,    4321, 0};
    v[13] = '{0, 1, 20, 20, 1, 20, 777, 1, 20, 888, 888,  888,  1,    0,    0,    0};
    v[14] = '{0, 1, 20, 4, 0, 0, 0,   0, 0, 0,      888,  0,    0,    0,    0,    0};
    v[15] = '{0, 1, 4, 20, 1, 4, 44,  0, 0, 0,      44,   888,  0,    0,    0,    0};
    v[16] = '{0, 1, 4, 20, 0, 0, 0,   0, 0, 0,      44,   888,  0,    44,   0,    0};
    for (int k = 0; k < 17; k++) begin
      step(v[k].rst, v[k].re, v[k].a1, v[k].a2, v[k].we, v[k].ia, v[k].da,
           v[k].web, v[k].ib, v[k].db);
      chk($sformatf("v%0d dut0 out1", k), int'(b0.out1), v[k].e1);
      chk($sformatf("v%0d dut0 out2", k), int'(b0.out2), v[k].e2);
      chk($sformatf("v%0d dut0 conflict", k), int'(b0.conflict), v[k].ec);
      chk($sformatf("v%0d dut1 out1", k), int'(b1.out1), v[k].f1);
      chk($sformatf("v%0d dut1 out2", k), int'(b1.out2), v[k].f2);
      chk($sformatf("v%0d dut1 conflict", k), int'(b1.conflict), v[k].fc);
      @(negedge clk);
    end
    // Fill 1..15 via port A and 17..31 via port B; DUT1 drops every port-B write.
    for (int i = 1; i < 16; i++) begin
      step(0, 0, 0, 0, 1, i, 100 + i, 1, i + 16, 200 + i);
      @(negedge clk);
    end
    for (int i = 1; i < 32; i++) begin
      step(0, 1, i, i, 0, 0, 0, 0, 0, 0);
      chk($sformatf("fill dut0 out1 r%0d", i), int'(b0.out1),
          i < 16 ? 100 + i : i == 16 ? 0 : 200 + i - 16);
      chk($sformatf("fill dut0 out2 r%0d", i), int'(b0.out2),
          i < 16 ? 100 + i : i == 16 ? 0 : 200 + i - 16);
      chk($sformatf("fill dut1 out1 r%0d", i), int'(b1.out1), i < 16 ? 100 + i : 0);
      @(negedge clk);
    end
    step(1, 1, 3, 3, 1, 3, 55, 0, 0, 0);
    chk("reset dut0 out1", int'(b0.out1), 0);
    chk("reset dut1 out1", int'(b1.out1), 0);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      step(0, 1, i, 31 - i, 0, 0, 0, 0, 0, 0);
      chk($sformatf("post-reset dut0 out1 r%0d", i), int'(b0.out1), 0);
      chk($sformatf("post-reset dut0 out2 r%0d", 31 - i), int'(b0.out2), 0);
      chk($sformatf("post-reset dut1 out1 r%0d", i), int'(b1.out1), 0);
      chk($sformatf("post-reset dut1 out2 r%0d", 31 - i), int'(b1.out2), 0);
      @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
